integer_masked_accum: RTL and testbench

Versat functional unit placed directly downstream of the integer compare unit. It consumes that unit's all-ones/all-zeros mask on `in0` and a data stream on `in1`, and accumulates the `in1` samples whose mask is set over a configurable window of `amount` samples. It also counts those samples and signals completion. Typical datapaths are compare-then-sum or compare-then-count, such as threshold histograms or match counts.

---
 rtl/integer_masked_accum.sv | 128 ++++++++++++
 tb/tb_integer_masked_accum.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/integer_masked_accum.sv
// integer_masked_accum
//   Masked accumulator sitting behind the integer compare unit. Samples of
//   in1 whose mask on in0 has any bit set are summed (out0) and counted
//   (out1) over a window of `amount` samples. The window starts `delay0`
//   cycles after an accepted run.
//   Optional build macro: INTEGER_MASKED_ACCUM_SATURATE_EN. When it is
//   defined, out0 saturates at all-ones. Otherwise out0 wraps.
module integer_masked_accum #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] amount,
  input  logic [DELAY_W-1:0] delay0,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DELAY_W-1:0] r_dcnt;
  logic [DATA_W-1:0]  r_scnt;
  logic [DATA_W-1:0]  r_sum;
  logic [DATA_W-1:0]  r_cnt;
  logic               r_done;
  logic               w_start;
  logic               w_hit;

  // The compare unit emits all-ones or all-zeros; any set bit counts as a hit.
  assign w_start = run & running;
  assign w_hit   = |in0;

  // Sum update. The saturating build clamps on carry-out, so a saturated
  // sum stays at all-ones until the next run clears it.
  function automatic logic [DATA_W-1:0] f_acc(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
`ifdef INTEGER_MASKED_ACCUM_SATURATE_EN
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
`else
    return a + b;
`endif
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state. A dropped running flag wins over run. A run from any state
  // restarts the window.
  always_comb begin
    w_next = r_state;
    if (!running) begin
      w_next = S_IDLE;
    end else if (run) begin
      if (delay0 != '0)      w_next = S_DELAY;
      else if (amount != '0) w_next = S_ACCUM;
      else                   w_next = S_DONE;
    end else begin
      case (r_state)
        S_DELAY: begin
          if (r_dcnt <= DELAY_W'(1))
            w_next = (r_scnt != '0) ? S_ACCUM : S_DONE;
        end
        S_ACCUM: begin
          if (r_scnt <= DATA_W'(1)) w_next = S_DONE;
        end
        default: w_next = r_state;
      endcase
    end
  end

  // Counters, sums and the done flag. done is raised in the same edge that
  // ends an accumulation window. On a zero-length window it is raised one
  // cycle after DONE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dcnt <= '0;
      r_scnt <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b1;
    end else if (!running) begin
      r_done <= 1'b1;
    end else if (w_start) begin
      r_dcnt <= delay0;
      r_scnt <= amount;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        S_DELAY: r_dcnt <= r_dcnt - DELAY_W'(1);
        S_ACCUM: begin
          if (w_hit) begin
            r_sum <= f_acc(r_sum, in1);
            r_cnt <= r_cnt + DATA_W'(1);
          end
          r_scnt <= r_scnt - DATA_W'(1);
          if (r_scnt <= DATA_W'(1)) r_done <= 1'b1;
        end
        S_DONE:  r_done <= 1'b1;
        default: r_done <= r_done;
      endcase
    end
  end

  assign out0 = r_sum;
  assign out1 = r_cnt;
  assign done = r_done;

endmodule

// File: tb/tb_integer_masked_accum.sv
// Bench for integer_masked_accum: table of windows with a result scoreboard,
// plus hand-written reset, restart and abort sequences.
module tb_integer_masked_accum;

  logic        clk = 1'b0;
  logic        rst, running, run;
  logic [31:0] in0, in1, amount;
  logic [7:0]  delay0;
  logic [31:0] out0, out1;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  integer_masked_accum #(.DATA_W(32), .DELAY_W(8)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run),
    .in0(in0), .in1(in1), .amount(amount), .delay0(delay0),
    .out0(out0), .out1(out1), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       amt;
    logic [7:0]        dly;
    logic [3:0][31:0]  mask;
    logic [3:0][31:0]  data;
    logic [31:0]       exp_sum;
    logic [31:0]       exp_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] cnt;
  } res_t;

  vec_t vecs[7];
  res_t sb[$];

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_window(input int idx);
    res_t r;
    int   waited;
    amount = vecs[idx].amt;
    delay0 = vecs[idx].dly;
    run    = 1'b1;
    in0    = ONES;
    in1    = 32'd999;
    sb.push_back('{sum: vecs[idx].exp_sum, cnt: vecs[idx].exp_cnt});
    tick();
    run = 1'b0;
    check($sformatf("v%0d done_cleared", idx), {31'd0, done}, 32'd0);
    repeat (int'(vecs[idx].dly)) tick();
    for (int i = 0; i < int'(vecs[idx].amt); i++) begin
      in0 = vecs[idx].mask[i];
      in1 = vecs[idx].data[i];
      tick();
    end
    in0 = ONES;
    in1 = 32'd555;
    if (vecs[idx].amt == 0) tick();
    waited = 0;
    while (!done && waited < 20) begin
      tick();
      waited++;
    end
    check($sformatf("v%0d done_latency", idx), waited, 0);
    r = sb.pop_front();
    check($sformatf("v%0d out0", idx), out0, r.sum);
    check($sformatf("v%0d out1", idx), out1, r.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{amt: 4, dly: 1, mask: {32'd0, ONES, 32'd0, ONES},
                data: {32'd40, 32'd30, 32'd20, 32'd10}, exp_sum: 40, exp_cnt: 2};
    vecs[1] = '{amt: 0, dly: 0, mask: '0, data: '0, exp_sum: 0, exp_cnt: 0};
    vecs[2] = '{amt: 3, dly: 0, mask: {32'd0, 32'd0, 32'h8000_0000, 32'h1},
                data: {32'd0, 32'd3, 32'd2, 32'd1}, exp_sum: 3, exp_cnt: 2};
`ifdef INTEGER_MASKED_ACCUM_SATURATE_EN
    vecs[3] = '{amt: 2, dly: 3, mask: {32'd0, 32'd0, ONES, ONES},
                data: {32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0}, exp_sum: ONES, exp_cnt: 2};
`else
    vecs[3] = '{amt: 2, dly: 3, mask: {32'd0, 32'd0, ONES, ONES},
                data: {32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0}, exp_sum: 32'h10, exp_cnt: 2};
`endif
    vecs[4] = '{amt: 4, dly: 2, mask: '0,
                data: {32'd7, 32'd7, 32'd7, 32'd7}, exp_sum: 0, exp_cnt: 0};
    vecs[5] = '{amt: 0, dly: 2, mask: '0, data: '0, exp_sum: 0, exp_cnt: 0};
    vecs[6] = '{amt: 1, dly: 0, mask: {32'd0, 32'd0, 32'd0, ONES},
                data: {32'd0, 32'd0, 32'd0, 32'h1234_5678}, exp_sum: 32'h1234_5678, exp_cnt: 1};

    // Reset with run held high: no window may start.
    rst = 1'b1; running = 1'b1; run = 1'b1;
    in0 = ONES; in1 = 32'd77; amount = 32'd4; delay0 = 8'd0;
    tick(); tick();
    check("rst out0", out0, 32'd0);
    check("rst out1", out1, 32'd0);
    check("rst done", {31'd0, done}, 32'd1);
    rst = 1'b0; run = 1'b0;
    tick(); tick();
    check("post_rst done", {31'd0, done}, 32'd1);
    check("post_rst out0", out0, 32'd0);

    // Table windows, issued back-to-back.
    for (int i = 0; i < 7; i++) do_window(i);
    check("sb empty", sb.size(), 0);

    // Restart: partial window of 3 hits of 100, then a 2-sample window.
    amount = 32'd8; delay0 = 8'd0; run = 1'b1;
    tick();
    run = 1'b0;
    in0 = ONES; in1 = 32'd100;
    tick(); tick(); tick();
    check("partial out0", out0, 32'd300);
    check("partial out1", out1, 32'd3);
    check("partial done", {31'd0, done}, 32'd0);
    amount = 32'd2; run = 1'b1;
    tick();
    run = 1'b0;
    check("restart cleared out0", out0, 32'd0);
    in1 = 32'd5; tick();
    in1 = 32'd7; tick();
    check("restart out0", out0, 32'd12);
    check("restart out1", out1, 32'd2);
    check("restart done", {31'd0, done}, 32'd1);

    // Abort: running drops after a sum of 15.
    amount = 32'd8; delay0 = 8'd0; run = 1'b1;
    tick();
    run = 1'b0;
    in0 = ONES;
    in1 = 32'd5;  tick();
    in1 = 32'd10; tick();
    check("abort pre out0", out0, 32'd15);
    running = 1'b0; in1 = 32'd100;
    tick();
    check("abort out0", out0, 32'd15);
    check("abort out1", out1, 32'd2);
    check("abort done", {31'd0, done}, 32'd1);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("ignored run done", {31'd0, done}, 32'd1);
    check("ignored run out0", out0, 32'd15);
    running = 1'b1;
    tick(); tick(); tick();
    check("idle hold out0", out0, 32'd15);
    check("idle hold out1", out1, 32'd2);
    check("idle hold done", {31'd0, done}, 32'd1);

    // Reset mid-window returns outputs to reset values.
    amount = 32'd4; delay0 = 8'd0; run = 1'b1;
    tick();
    run = 1'b0; in1 = 32'd9;
    tick(); tick();
    check("mid out0", out0, 32'd18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst out0", out0, 32'd0);
    check("midrst out1", out1, 32'd0);
    check("midrst done", {31'd0, done}, 32'd1);
    tick(); tick();
    check("midrst idle out0", out0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
